cpu_dbg_ctrl: RTL

- Hardware run-control and program-load unit for the parametrised multicycle CPU core.
- Replaces hierarchical testbench pokes and manual clock stepping with a command interface.
- Writes instruction memory, resets the core, steps it N clocks, free-runs it and halts it on PC breakpoints.
- Sits between the host/bench command port and the core's clock-enable, reset and imem write port.

---
 rtl/custom_types.sv | 25 ++
 rtl/dbg_bp_bank.sv | 37 +++
 rtl/cpu_dbg_ctrl.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/custom_types.sv
// Shared enums and constants for the debug run-control unit and its breakpoint bank.
package custom_types;

   typedef enum logic [2:0] {
      CMD_NOP    = 3'd0,
      CMD_PROG   = 3'd1,
      CMD_CRESET = 3'd2,
      CMD_STEP   = 3'd3,
      CMD_RUN    = 3'd4,
      CMD_HALT   = 3'd5,
      CMD_SETBP  = 3'd6,
      CMD_CLRBP  = 3'd7
   } dbg_cmd_t;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_PROG   = 3'd1,
      ST_CRESET = 3'd2,
      ST_STEP   = 3'd3,
      ST_RUN    = 3'd4
   } dbg_state_t;

   localparam int DBG_CNT_W = 32;

endpackage

// File: rtl/dbg_bp_bank.sv
// PC breakpoint bank: NUM_BP registered {enable, addr} entries, set/clear take effect next clock.
// match_o is a same-cycle compare against pc_i; no backpressure.
module dbg_bp_bank #(
   parameter int ADDR_W  = 4,
   parameter int INSTR_W = 8,
   parameter int NUM_BP  = 2
) (
   input  logic               clk_i,
   input  logic               rst_ni,
   input  logic               set_i,
   input  logic               clr_i,
   input  logic [INSTR_W-1:0] idx_i,
   input  logic [ADDR_W-1:0]  addr_i,
   input  logic [ADDR_W-1:0]  pc_i,
   output logic               match_o
);

   logic [NUM_BP-1:0] en_q;
   logic [ADDR_W-1:0] addr_q [NUM_BP];
   logic [NUM_BP-1:0] hit;

   for (genvar i = 0; i < NUM_BP; i++) begin : g_bp
      always_ff @(posedge clk_i) begin
         if (!rst_ni) begin
            en_q[i]   <= 1'b0;
            addr_q[i] <= '0;
         end else if ((set_i || clr_i) && idx_i == INSTR_W'(i)) begin
            en_q[i]   <= set_i;
            addr_q[i] <= addr_i;
         end
      end
      assign hit[i] = en_q[i] && (addr_q[i] == pc_i);
   end

   assign match_o = |hit;

endmodule

// File: rtl/cpu_dbg_ctrl.sv
// Run-control/program-load unit: PROG, CRESET, STEP, RUN/HALT and PC breakpoints; optional cycle_cnt
// under CPU_DBG_CYCLE_COUNTER_EN. cmd_ready low during PROG/CRESET/STEP; done/err pulse one cycle.
module cpu_dbg_ctrl
   import custom_types::*;
#(
   parameter int ADDR_W  = 4,
   parameter int INSTR_W = 8,
   parameter int STEP_W  = 8,
   parameter int NUM_BP  = 2
) (
   input  logic                 cpu_clk,
   input  logic                 cpu_reset_n,
   input  logic                 cmd_valid,
   output logic                 cmd_ready,
   input  dbg_cmd_t             cmd_op,
   input  logic [ADDR_W-1:0]    cmd_addr,
   input  logic [INSTR_W-1:0]   cmd_data,
   input  logic [STEP_W-1:0]    cmd_count,
   input  logic [ADDR_W-1:0]    core_pc,
   input  logic                 core_fetch,
   output logic                 core_clk_en,
   output logic                 core_reset,
   output logic                 imem_we,
   output logic [ADDR_W-1:0]    imem_waddr,
   output logic [INSTR_W-1:0]   imem_wdata,
   output logic                 halted,
   output logic                 bp_hit,
   output logic                 cmd_done,
   output logic                 cmd_err,
   output logic [DBG_CNT_W-1:0] cycle_cnt
);

   dbg_state_t         state_q;
   logic [STEP_W-1:0]  cnt_q;
   logic [ADDR_W-1:0]  addr_q;
   logic [INSTR_W-1:0] data_q;
   logic               skip_bp_q;
   logic               bp_hit_q;
   logic               done_q;
   logic               err_q;

   logic cmd_fire;
   logic idle_fire;
   logic idx_bad;
   logic bp_raw;
   logic bp_stop;
   logic halt_req;
   logic bp_set;
   logic bp_clr;

   assign cmd_ready = (state_q == ST_IDLE) || (state_q == ST_RUN);
   assign cmd_fire  = cmd_valid && cmd_ready;
   assign idle_fire = cmd_fire && (state_q == ST_IDLE);
   assign idx_bad   = cmd_data >= INSTR_W'(NUM_BP);
   assign bp_set    = idle_fire && (cmd_op == CMD_SETBP) && !idx_bad;
   assign bp_clr    = idle_fire && (cmd_op == CMD_CLRBP) && !idx_bad;

   // The stop is combinational so the core never starts the fetch at the breakpoint PC.
   assign bp_stop  = (state_q == ST_RUN) && core_fetch && bp_raw && !skip_bp_q;
   assign halt_req = (state_q == ST_RUN) && cmd_fire && (cmd_op == CMD_HALT);

   always_comb begin
      core_clk_en = 1'b0;
      case (state_q)
         ST_CRESET, ST_STEP: core_clk_en = 1'b1;
         ST_RUN:             core_clk_en = !bp_stop && !halt_req;
         default:            core_clk_en = 1'b0;
      endcase
   end

   assign core_reset = (state_q == ST_CRESET);
   assign imem_we    = (state_q == ST_PROG);
   assign imem_waddr = addr_q;
   assign imem_wdata = data_q;
   assign halted     = !((state_q == ST_RUN) || (state_q == ST_STEP));
   assign bp_hit     = bp_hit_q;
   assign cmd_done   = done_q;
   assign cmd_err    = err_q;

   dbg_bp_bank #(
      .ADDR_W  (ADDR_W),
      .INSTR_W (INSTR_W),
      .NUM_BP  (NUM_BP)
   ) u_bp_bank (
      .clk_i   (cpu_clk),
      .rst_ni  (cpu_reset_n),
      .set_i   (bp_set),
      .clr_i   (bp_clr),
      .idx_i   (cmd_data),
      .addr_i  (cmd_addr),
      .pc_i    (core_pc),
      .match_o (bp_raw)
   );

   always_ff @(posedge cpu_clk) begin
      if (!cpu_reset_n) begin
         state_q   <= ST_IDLE;
         cnt_q     <= '0;
         addr_q    <= '0;
         data_q    <= '0;
         skip_bp_q <= 1'b0;
         bp_hit_q  <= 1'b0;
         done_q    <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         done_q <= 1'b0;
         err_q  <= 1'b0;
         if (core_clk_en && !core_fetch)
            skip_bp_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (cmd_valid) begin
                  bp_hit_q <= 1'b0;
                  case (cmd_op)
                     CMD_NOP, CMD_HALT: done_q <= 1'b1;
                     CMD_PROG: begin
                        addr_q  <= cmd_addr;
                        data_q  <= cmd_data;
                        state_q <= ST_PROG;
                     end
                     CMD_CRESET: state_q <= ST_CRESET;
                     CMD_STEP: begin
                        if (cmd_count == '0) begin
                           done_q <= 1'b1;
                        end else begin
                           cnt_q   <= cmd_count;
                           state_q <= ST_STEP;
                           done_q  <= (cmd_count == STEP_W'(1));
                        end
                     end
                     CMD_RUN: begin
                        state_q   <= ST_RUN;
                        skip_bp_q <= bp_raw;
                     end
                     CMD_SETBP, CMD_CLRBP: begin
                        err_q  <= idx_bad;
                        done_q <= !idx_bad;
                     end
                  endcase
               end
            end
            ST_PROG: begin
               state_q <= ST_IDLE;
               done_q  <= 1'b1;
            end
            ST_CRESET: begin
               state_q   <= ST_IDLE;
               done_q    <= 1'b1;
               skip_bp_q <= 1'b0;
            end
            ST_STEP: begin
               // done is registered, so it is raised one count early to land on the last clock
               cnt_q  <= cnt_q - STEP_W'(1);
               done_q <= (cnt_q == STEP_W'(2));
               if (cnt_q == STEP_W'(1))
                  state_q <= ST_IDLE;
            end
            ST_RUN: begin
               if (bp_stop) begin
                  state_q  <= ST_IDLE;
                  bp_hit_q <= 1'b1;
                  done_q   <= 1'b1;
               end else if (halt_req) begin
                  state_q  <= ST_IDLE;
                  bp_hit_q <= 1'b0;
                  done_q   <= 1'b1;
               end
               if (cmd_fire && cmd_op != CMD_HALT)
                  err_q <= 1'b1;
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

`ifdef CPU_DBG_CYCLE_COUNTER_EN
   logic [DBG_CNT_W-1:0] cyc_q;

   always_ff @(posedge cpu_clk) begin
      if (!cpu_reset_n)
         cyc_q <= '0;
      else if (core_clk_en)
         cyc_q <= cyc_q + DBG_CNT_W'(1);
   end

   assign cycle_cnt = cyc_q;
`else
   assign cycle_cnt = '0;
`endif

endmodule
